// File: rtl/adder_sched.sv
// -----------------------------------------------------------------------------
// adder_sched
//
// Round-robin scheduler sharing one external 8-bit ripple-carry adder between
// two requesters. Each accepted request is an NBYTES-wide addition that is run
// byte-serially, LSB first, with the adder's carry-out fed back as the next
// byte's carry-in. The full-width sum and final carry are returned on a
// valid/ready response port.
//
// Optional feature macro: ADDER_SCHED_OVF_EN
//   When defined, adds output rsp_ovf (two's-complement signed overflow of the
//   full-width add), valid and stable alongside rsp_sum.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid / reqN_ready   request handshake, N = 0, 1
//   reqN_a, reqN_b, reqN_ci   request operands (sampled only at acceptance)
//   add_a, add_b, add_ci      byte and carry presented to the shared adder
//   add_s, add_cout           shared adder result (combinational)
//   rsp_valid / rsp_ready     response handshake
//   rsp_id                    requester that was served
//   rsp_sum, rsp_cout         full-width sum and final carry-out
//   rsp_ovf                   signed overflow (ADDER_SCHED_OVF_EN only)
// -----------------------------------------------------------------------------
module adder_sched #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [8*NBYTES-1:0]   req0_a,
    input  logic [8*NBYTES-1:0]   req0_b,
    input  logic                  req0_ci,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [8*NBYTES-1:0]   req1_a,
    input  logic [8*NBYTES-1:0]   req1_b,
    input  logic                  req1_ci,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_ci,
    input  logic [7:0]            add_s,
    input  logic                  add_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [8*NBYTES-1:0]   rsp_sum,
    output logic                  rsp_cout
`ifdef ADDER_SCHED_OVF_EN
    ,
    output logic                  rsp_ovf
`endif
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

    logic [1:0]    state_reg;
    logic          prio_reg;
    logic          id_reg;
    logic          carry_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [7:0]    sum_bytes_reg [NBYTES];

    logic [7:0]    a_bytes [NBYTES];
    logic [7:0]    b_bytes [NBYTES];

    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          sel;

    // Split the latched operands into bytes and assemble the result bytes.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
            assign a_bytes[gi]          = a_reg[gi*8 +: 8];
            assign b_bytes[gi]          = b_reg[gi*8 +: 8];
            assign rsp_sum[gi*8 +: 8]   = sum_bytes_reg[gi];
        end
    endgenerate

    // Arbitration: a lone valid always wins; on a tie the prio requester wins.
    // Ready is a function of state and the valid lines only, and is held low
    // while reset is asserted so no handshake can coincide with reset.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || !prio_reg);
        grant1     = req1_valid && (!req0_valid ||  prio_reg);
        req0_ready = !rst && (state_reg == ST_IDLE) && grant0;
        req1_ready = !rst && (state_reg == ST_IDLE) && grant1;
        accept     = req0_ready || req1_ready;
        sel        = req1_ready;
    end

    // Adder drive: only meaningful in RUN, forced to zero otherwise.
    always_comb begin
        add_a  = 8'd0;
        add_b  = 8'd0;
        add_ci = 1'b0;
        if (state_reg == ST_RUN) begin
            add_a  = a_bytes[cnt_reg];
            add_b  = b_bytes[cnt_reg];
            add_ci = carry_reg;
        end
    end

    assign rsp_valid = (state_reg == ST_DONE);
    assign rsp_id    = id_reg;
    // The carry register holds the final carry once RUN completes, so it
    // doubles as the response carry-out.
    assign rsp_cout  = carry_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            prio_reg  <= 1'b0;
            id_reg    <= 1'b0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        a_reg     <= sel ? req1_a  : req0_a;
                        b_reg     <= sel ? req1_b  : req0_b;
                        carry_reg <= sel ? req1_ci : req0_ci;
                        id_reg    <= sel;
                        cnt_reg   <= '0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry_reg <= add_cout;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BYTE) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state_reg <= ST_IDLE;
                        prio_reg  <= ~id_reg;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Result byte capture, one byte per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NBYTES; i++) begin
                sum_bytes_reg[i] <= 8'd0;
            end
        end else if (state_reg == ST_RUN) begin
            sum_bytes_reg[cnt_reg] <= add_s;
        end
    end

`ifdef ADDER_SCHED_OVF_EN
    logic ovf_reg;

    // Signed overflow = carry into the MSB xor carry out of the MSB. The carry
    // into bit 7 of the top byte is recovered as a ^ b ^ s at that bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if ((state_reg == ST_RUN) && (cnt_reg == LAST_BYTE)) begin
            ovf_reg <= (a_reg[W-1] ^ b_reg[W-1] ^ add_s[7]) ^ add_cout;
        end
    end

    assign rsp_ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_adder_sched.sv
// -----------------------------------------------------------------------------
// tb_adder_sched
//
// Scoreboard bench for adder_sched (NBYTES = 4). A behavioural model of the
// external 8-bit adder is attached to the add_* port. Expected responses are
// computed with plain full-width arithmetic at the moment a request handshake
// is observed and queued; a monitor pops and compares them when the DUT
// completes a response handshake. The monitor also tracks arbitration,
// latency, busy-time acceptance and response stability during back-pressure.
// -----------------------------------------------------------------------------
module tb_adder_sched;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk;
    logic          rst;
    logic          req0_valid, req0_ready, req0_ci;
    logic [W-1:0]  req0_a, req0_b;
    logic          req1_valid, req1_ready, req1_ci;
    logic [W-1:0]  req1_a, req1_b;
    logic [7:0]    add_a, add_b, add_s;
    logic          add_ci, add_cout;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [W-1:0]  rsp_sum;
`ifdef ADDER_SCHED_OVF_EN
    logic          rsp_ovf;
`endif

    adder_sched #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ci    (req0_ci),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ci    (req1_ci),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_ci     (add_ci),
        .add_s      (add_s),
        .add_cout   (add_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout)
`ifdef ADDER_SCHED_OVF_EN
        ,
        .rsp_ovf    (rsp_ovf)
`endif
    );

    // External shared adder.
    assign {add_cout, add_s} = 9'(add_a) + 9'(add_b) + 9'(add_ci);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic          id;
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
        int            acc;
    } exp_t;

    exp_t sb[$];
    logic order_q[$];
    bit   busy   = 1'b0;
    logic m_prio = 1'b0;
    int   last_acc_cyc = 0;
    int   last_rsp_cyc = 0;
    int   rdy_mode = 0;   // 0: hold high, 1: random, 2: hold low

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        r = '0;
        case ($urandom_range(0, 5))
            0: r = '0;
            1: r = '1;
            2: r = {1'b0, {(W-1){1'b1}}};
            default: begin
                for (int i = 0; i < NB; i++) r[i*8 +: 8] = 8'($urandom);
            end
        endcase
        return r;
    endfunction

    // Response back-pressure driver (single writer of rsp_ready).
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    exp_t         m_e;
    logic [W:0]   m_full;
    logic [W-1:0] m_a, m_b;
    logic         m_ci;
    bit           prev_valid = 1'b0;
    bit           prev_ready = 1'b0;
    logic [W-1:0] prev_sum;
    logic         prev_id, prev_cout;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            busy       = 1'b0;
            m_prio     = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (req0_ready || req1_ready) begin
                check("both_ready", 64'(req0_ready && req1_ready), 64'd0);
                check("accept_while_busy", 64'(busy), 64'd0);
                if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                    m_e.id = req1_ready;
                    m_a    = m_e.id ? req1_a  : req0_a;
                    m_b    = m_e.id ? req1_b  : req0_b;
                    m_ci   = m_e.id ? req1_ci : req0_ci;
                    m_full = {1'b0, m_a} + {1'b0, m_b} + (W+1)'(m_ci);
                    m_e.sum  = m_full[W-1:0];
                    m_e.cout = m_full[W];
                    m_e.ovf  = (m_a[W-1] == m_b[W-1]) && (m_full[W-1] != m_a[W-1]);
                    m_e.acc  = cyc;
                    if (req0_valid && req1_valid)
                        check("arb_winner", 64'(m_e.id), 64'(m_prio));
                    sb.push_back(m_e);
                    busy = 1'b1;
                    last_acc_cyc = cyc;
                end
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    m_e = sb[0];
                    if (prev_valid && !prev_ready) begin
                        check("stall_sum",  64'(rsp_sum),  64'(prev_sum));
                        check("stall_id",   64'(rsp_id),   64'(prev_id));
                        check("stall_cout", 64'(rsp_cout), 64'(prev_cout));
                    end else begin
                        check("latency", 64'(cyc - m_e.acc), 64'(NB + 1));
                    end
                    if (rsp_ready) begin
                        check("rsp_id",   64'(rsp_id),   64'(m_e.id));
                        check("rsp_sum",  64'(rsp_sum),  64'(m_e.sum));
                        check("rsp_cout", 64'(rsp_cout), 64'(m_e.cout));
`ifdef ADDER_SCHED_OVF_EN
                        check("rsp_ovf",  64'(rsp_ovf),  64'(m_e.ovf));
`endif
                        $display("[TB] rsp id=%0d sum=%08h cout=%0d (expected sum=%08h cout=%0d)",
                                 rsp_id, rsp_sum, rsp_cout, m_e.sum, m_e.cout);
                        void'(sb.pop_front());
                        order_q.push_back(m_e.id);
                        busy         = 1'b0;
                        m_prio       = ~m_e.id;
                        last_rsp_cyc = cyc;
                    end
                end
            end else if (prev_valid && !prev_ready) begin
                check("valid_dropped", 64'(rsp_valid), 64'd1);
            end
            prev_valid = rsp_valid;
            prev_ready = rsp_ready;
            prev_sum   = rsp_sum;
            prev_id    = rsp_id;
            prev_cout  = rsp_cout;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int  t;
        bit  done;
        tick();
        if (id) begin
            req1_a = a; req1_b = b; req1_ci = ci; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_ci = ci; req0_valid = 1'b1;
        end
        t = 0;
        done = 1'b0;
        while (!done && t < 400) begin
            @(negedge clk);
            if (id) done = req1_valid && req1_ready;
            else    done = req0_valid && req0_ready;
            t++;
        end
        if (!done) check("issue_timeout", 64'(done), 64'd1);
        tick();
        // Drop valid and scramble operands while the operation is in flight.
        if (id) begin
            req1_valid = 1'b0; req1_a = rand_word(); req1_b = rand_word(); req1_ci = 1'($urandom);
        end else begin
            req0_valid = 1'b0; req0_a = rand_word(); req0_b = rand_word(); req0_ci = 1'($urandom);
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        @(negedge clk);
        check({tag, "_req0_ready"}, 64'(req0_ready), 64'd0);
        check({tag, "_req1_ready"}, 64'(req1_ready), 64'd0);
        check({tag, "_rsp_valid"},  64'(rsp_valid),  64'd0);
        check({tag, "_rsp_id"},     64'(rsp_id),     64'd0);
        check({tag, "_rsp_sum"},    64'(rsp_sum),    64'd0);
        check({tag, "_rsp_cout"},   64'(rsp_cout),   64'd0);
        check({tag, "_add_a"},      64'(add_a),      64'd0);
        check({tag, "_add_b"},      64'(add_b),      64'd0);
        check({tag, "_add_ci"},     64'(add_ci),     64'd0);
`ifdef ADDER_SCHED_OVF_EN
        check({tag, "_rsp_ovf"},    64'(rsp_ovf),    64'd0);
`endif
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("drain", 64'(sb.size() != 0 || busy), 64'd0);
    endtask

    task automatic wait_rsp();
        int t;
        t = 0;
        @(negedge clk);
        while (!rsp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rsp_timeout", 64'(rsp_valid), 64'd1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    logic exp_order [4];

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ci = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ci = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset("reset");

        // Directed single operations.
        issue(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        drain();
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        drain();

        // Both requesters valid from reset: strict alternation 0,1,0,1.
        do_reset();
        order_q.delete();
        fork
            begin
                issue(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
                issue(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
            end
            begin
                issue(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0);
                issue(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0);
            end
        join
        drain();
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
        check("order_len", 64'(order_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < order_q.size(); i++)
            check("order", 64'(order_q[i]), 64'(exp_order[i]));

        // Back-pressure in DONE with req1 waiting.
        rdy_mode = 2;
        issue(1'b0, rand_word(), rand_word(), 1'b1);
        fork
            issue(1'b1, rand_word(), rand_word(), 1'b0);
            begin
                wait_rsp();
                repeat (3) @(posedge clk);
                rdy_mode = 0;
            end
        join
        check("accept_after_rsp", 64'(last_acc_cyc - last_rsp_cyc), 64'd1);
        drain();

        // Reset in the second RUN cycle discards the operation.
        issue(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("midrun_reset");
        repeat (10) @(negedge clk);
        issue(1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0);
        drain();

`ifdef ADDER_SCHED_OVF_EN
        issue(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        drain();
`endif

        // Randomized traffic on both requesters with random back-pressure.
        rdy_mode = 1;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    issue(1'b0, rand_word(), rand_word(), 1'($urandom));
                end
            end
            begin
                for (int j = 0; j < 25; j++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    issue(1'b1, rand_word(), rand_word(), 1'($urandom));
                end
            end
        join
        drain();
        rdy_mode = 0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
